// File: rtl/pixel_ram_writer.sv
// Assembles 12-bit RGB pixels from pairs of received bytes and writes them
// to consecutive RAM addresses while the system sits in the image-load state.
module pixel_ram_writer #(
   parameter int IMG_W  = 320,
   parameter int IMG_H  = 240,
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        state,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [11:0]       wr_data,
   output logic              busy,
   output logic              frame_done,
   output logic              loaded
);

   localparam logic [7:0]        LOAD_STATE = 8'h02;
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(IMG_W * IMG_H - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HI    = 3'd1,
      LO    = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } fsm_t;

   fsm_t              fsm;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        hi_byte;
   logic              load_req;

   assign load_req = (state == LOAD_STATE);

   // rx_valid is a one-cycle strobe with no back-pressure: a byte is consumed
   // in the cycle it is presented or lost, so DONE and IDLE simply drop it.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm        <= IDLE;
         addr       <= '0;
         hi_byte    <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         loaded     <= 1'b0;
      end else begin
         wr_en      <= 1'b0;
         frame_done <= 1'b0;
         case (fsm)
            IDLE: begin
               if (load_req) begin
                  fsm    <= HI;
                  addr   <= '0;
                  loaded <= 1'b0;
                  busy   <= 1'b1;
               end
            end
            HI: begin
               if (!load_req) begin
                  fsm  <= IDLE;
                  busy <= 1'b0;
               end else if (rx_valid) begin
                  hi_byte <= rx_data;
                  fsm     <= LO;
               end
            end
            LO: begin
               if (!load_req) begin
                  fsm  <= IDLE;
                  busy <= 1'b0;
               end else if (rx_valid) begin
                  wr_en   <= 1'b1;
                  wr_addr <= addr;
                  wr_data <= {hi_byte, rx_data[3:0]};
                  fsm     <= WRITE;
               end
            end
            WRITE: begin
               // The write strobe is already out; the last pixel closes the
               // frame even if the load state drops in this same cycle.
               if (addr == LAST_ADDR) begin
                  fsm        <= DONE;
                  frame_done <= 1'b1;
                  loaded     <= 1'b1;
                  busy       <= 1'b0;
               end else if (!load_req) begin
                  fsm  <= IDLE;
                  busy <= 1'b0;
               end else begin
                  addr <= addr + 1'b1;
                  if (rx_valid) begin
                     hi_byte <= rx_data;
                     fsm     <= LO;
                  end else begin
                     fsm <= HI;
                  end
               end
            end
            DONE: begin
               if (!load_req) fsm <= IDLE;
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_ram_writer.sv
// Directed bench for pixel_ram_writer with a 4x2 image (8 pixels, 3-bit address).
module tb_pixel_ram_writer;

   localparam int IMG_W  = 4;
   localparam int IMG_H  = 2;
   localparam int ADDR_W = 3;

   logic              clk;
   logic              rst;
   logic [7:0]        state;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [11:0]       wr_data;
   logic              busy;
   logic              frame_done;
   logic              loaded;

   int compared   = 0;
   int mismatched = 0;
   int write_count = 0;
   int done_count  = 0;
   int snap;

   pixel_ram_writer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .state      (state),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .frame_done (frame_done),
      .loaded     (loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts write strobes and frame_done pulses, sampled mid-cycle.
   always @(negedge clk) begin
      if (wr_en) write_count <= write_count + 1;
      if (frame_done) done_count <= done_count + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared = compared + 1;
      assert (obs === exp) else begin
         mismatched = mismatched + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst      = 1'b1;
      state    = 8'h00;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      tick();
      tick();
      chk("rst_wr_en", 32'(wr_en), 0);
      chk("rst_wr_addr", 32'(wr_addr), 0);
      chk("rst_wr_data", 32'(wr_data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_loaded", 32'(loaded), 0);
      rst = 1'b0;
      tick();

      // Bytes outside the load state are ignored.
      state = 8'h03;
      snap  = write_count;
      for (int i = 0; i < 10; i++) send_byte(8'(8'h30 + i));
      tick();
      chk("noload_writes", 32'(write_count - snap), 0);
      chk("noload_busy", 32'(busy), 0);

      // Single pixel: A5 then F3 gives A53 at address 0.
      state = 8'h02;
      tick();
      chk("single_busy", 32'(busy), 1);
      send_byte(8'hA5);
      chk("single_no_early_wr", 32'(wr_en), 0);
      send_byte(8'hF3);
      chk("single_wr_en", 32'(wr_en), 1);
      chk("single_wr_addr", 32'(wr_addr), 0);
      chk("single_wr_data", 32'(wr_data), 32'h0A53);
      tick();
      chk("single_wr_en_drop", 32'(wr_en), 0);
      chk("single_data_hold", 32'(wr_data), 32'h0A53);
      state = 8'h00;
      tick();
      chk("single_abort_busy", 32'(busy), 0);
      chk("single_abort_loaded", 32'(loaded), 0);

      // Full frame, back-to-back bytes: pixel k+1 = {00, k+1} at address k.
      state = 8'h02;
      tick();
      snap = write_count;
      send_byte(8'h00);
      for (int k = 0; k < 8; k++) begin
         send_byte(8'(k + 1));
         chk($sformatf("frame_wr_en_%0d", k), 32'(wr_en), 1);
         chk($sformatf("frame_wr_addr_%0d", k), 32'(wr_addr), 32'(k));
         chk($sformatf("frame_wr_data_%0d", k), 32'(wr_data), 32'(k + 1));
         if (k < 7) send_byte(8'h00);
      end
      chk("frame_busy_last", 32'(busy), 1);
      send_byte(8'hEE);
      chk("frame_done_pulse", 32'(frame_done), 1);
      chk("frame_loaded", 32'(loaded), 1);
      chk("frame_busy_clear", 32'(busy), 0);
      chk("frame_no_17th_wr", 32'(wr_en), 0);
      send_byte(8'h12);
      send_byte(8'h34);
      chk("frame_done_once", 32'(frame_done), 0);
      chk("frame_loaded_hold", 32'(loaded), 1);
      chk("frame_write_total", 32'(write_count - snap), 8);
      chk("frame_done_total", 32'(done_count), 1);

      // Leaving and re-entering the load state clears loaded.
      state = 8'h00;
      tick();
      chk("done_idle_loaded", 32'(loaded), 1);
      state = 8'h02;
      tick();
      chk("reload_loaded_clr", 32'(loaded), 0);
      chk("reload_busy", 32'(busy), 1);

      // Abort after 3 bytes: one write at 0, third byte discarded.
      snap = write_count;
      send_byte(8'h11);
      send_byte(8'h22);
      chk("abort_wr_addr", 32'(wr_addr), 0);
      chk("abort_wr_data", 32'(wr_data), 32'h0112);
      send_byte(8'h33);
      state = 8'h00;
      tick();
      chk("abort_busy", 32'(busy), 0);
      chk("abort_loaded", 32'(loaded), 0);
      tick();
      chk("abort_writes", 32'(write_count - snap), 1);
      state = 8'h02;
      tick();
      send_byte(8'h44);
      send_byte(8'h55);
      chk("reentry_wr_en", 32'(wr_en), 1);
      chk("reentry_wr_addr", 32'(wr_addr), 0);
      chk("reentry_wr_data", 32'(wr_data), 32'h0445);

      // Reset mid-frame after 2 pixels, then restart at address 0.
      send_byte(8'h66);
      send_byte(8'h77);
      chk("mid_wr_addr", 32'(wr_addr), 1);
      chk("mid_wr_data", 32'(wr_data), 32'h0667);
      rst = 1'b1;
      tick();
      chk("midrst_wr_en", 32'(wr_en), 0);
      chk("midrst_wr_addr", 32'(wr_addr), 0);
      chk("midrst_wr_data", 32'(wr_data), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_frame_done", 32'(frame_done), 0);
      chk("midrst_loaded", 32'(loaded), 0);
      rst = 1'b0;
      tick();
      chk("postrst_busy", 32'(busy), 1);
      send_byte(8'h88);
      send_byte(8'h99);
      chk("postrst_wr_en", 32'(wr_en), 1);
      chk("postrst_wr_addr", 32'(wr_addr), 0);
      chk("postrst_wr_data", 32'(wr_data), 32'h0889);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
